uart_frame_collector: RTL and testbench

- Generalised UART front end for the search engine: collects a delimiter-terminated frame of FRAME_BYTES bytes from the UART receive handshake into a wide register.
- Hands the frame downstream on a valid/ready interface.
- Returns a one-byte reply to the host through the UART transmit handshake: the comparator result, an echo byte, or an error code.
- Sits between the UART driver and the hash compare logic in the top level.

---
 rtl/uart_frame_pkg.sv | 26 ++
 rtl/uart_tx_handshake.sv | 55 +++++
 rtl/uart_frame_collector.sv | 139 +++++++++++++
 tb/tb_uart_frame_collector.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and default constants for the UART frame collector.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    DELIVER,
    WAIT_RESULT,
    SEND,
    TX_WAIT
  } state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_PEND,
    TX_REQ,
    TX_HOLD
  } tx_phase_e;

  localparam logic [7:0] DELIM_COMMA = 8'h2C;
  localparam logic [7:0] ERR_BYTE    = 8'h45;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_tx_handshake.sv
// One-byte transmit request: raise Tx_Send once the UART is idle, drop it
// when busy is seen, and pulse done when the transmitter goes idle again.
module uart_tx_handshake
  import uart_frame_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_send,
  output logic       o_done
);

  tx_phase_e  r_phase;
  logic [7:0] r_tx_data;
  logic       r_tx_send;

  assign o_tx_data = r_tx_data;
  assign o_tx_send = r_tx_send;
  assign o_done    = (r_phase == TX_HOLD) && !i_tx_busy;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase   <= TX_IDLE;
      r_tx_data <= '0;
      r_tx_send <= 1'b0;
    end else begin
      case (r_phase)
        TX_IDLE: if (i_load) begin
          r_tx_data <= i_byte;
          // request in the load cycle when the UART is already idle
          if (!i_tx_busy) begin
            r_tx_send <= 1'b1;
            r_phase   <= TX_REQ;
          end else begin
            r_phase <= TX_PEND;
          end
        end
        TX_PEND: if (!i_tx_busy) begin
          r_tx_send <= 1'b1;
          r_phase   <= TX_REQ;
        end
        TX_REQ: if (i_tx_busy) begin
          r_tx_send <= 1'b0;
          r_phase   <= TX_HOLD;
        end
        TX_HOLD: if (!i_tx_busy) r_phase <= TX_IDLE;
        default: r_phase <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_collector.sv
// Collects a delimiter-terminated frame from the UART receive handshake,
// hands it downstream on valid/ready and returns a one-byte reply.
//   state       | meaning
//   COLLECT     | shifting in bytes until the delimiter
//   DELIVER     | Frame_Valid high, waiting for Frame_Ready
//   WAIT_RESULT | waiting for the comparator result
//   SEND        | reply loaded, Tx_Send pending or raised
//   TX_WAIT     | transmitter busy with the reply
module uart_frame_collector
  import uart_frame_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 16,
  parameter logic [7:0]  DELIM       = DELIM_COMMA,
  parameter bit          ECHO_MODE   = 1'b0,
  parameter logic [7:0]  ERR_CODE    = ERR_BYTE
)(
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_ready,
  output logic                     o_rx_ack,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_send,
  input  logic                     i_tx_busy,
  output logic [8*FRAME_BYTES-1:0] o_frame_data,
  output logic                     o_frame_valid,
  input  logic                     i_frame_ready,
  input  logic                     i_result_valid,
  input  logic [7:0]               i_result_data,
  output logic [7:0]               o_last_byte,
  output logic [7:0]               o_err_count
);

  localparam int unsigned   FW   = 8 * FRAME_BYTES;
  localparam int unsigned   CW   = $clog2(FRAME_BYTES + 1);
  localparam logic [CW-1:0] FULL = CW'(FRAME_BYTES);

  state_e        r_state;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_rx_ack;
  logic [FW-1:0] r_frame;
  logic          r_frame_valid;
  logic [7:0]    r_last_byte;
  logic [7:0]    r_err_count;

  logic       w_consume;
  logic       w_is_delim;
  logic       w_frame_ok;
  logic       w_load;
  logic [7:0] w_reply;
  logic       w_tx_send;
  logic       w_tx_done;

  always_comb begin
    w_consume  = i_rx_ready && !r_rx_ack && (r_state == COLLECT);
    w_is_delim = (i_rx_data == DELIM);
    w_frame_ok = (r_count == FULL) && !r_overflow;
    w_load     = 1'b0;
    w_reply    = ERR_CODE;
    case (r_state)
      COLLECT: if (w_consume && w_is_delim && !w_frame_ok) w_load = 1'b1;
      DELIVER: if (ECHO_MODE && r_frame_valid && i_frame_ready) begin
        w_load  = 1'b1;
        w_reply = r_frame[7:0];
      end
      WAIT_RESULT: if (i_result_valid) begin
        w_load  = 1'b1;
        w_reply = i_result_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= COLLECT;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_rx_ack      <= 1'b0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_last_byte   <= '0;
      r_err_count   <= '0;
    end else begin
      if (w_consume) r_rx_ack <= 1'b1;
      else if (r_rx_ack && !i_rx_ready) r_rx_ack <= 1'b0;

      case (r_state)
        COLLECT: if (w_consume) begin
          if (w_is_delim) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            if (w_frame_ok) begin
              r_frame_valid <= 1'b1;
              r_state       <= DELIVER;
            end else begin
              r_err_count <= sat_inc8(r_err_count);
              r_state     <= SEND;
            end
          end else begin
            // a full frame keeps shifting, dropping its oldest byte
            r_frame     <= (r_frame << 8) | FW'(i_rx_data);
            r_last_byte <= i_rx_data;
            if (r_count == FULL) r_overflow <= 1'b1;
            else r_count <= r_count + 1'b1;
          end
        end
        DELIVER: if (r_frame_valid && i_frame_ready) begin
          r_frame_valid <= 1'b0;
          r_state       <= ECHO_MODE ? SEND : WAIT_RESULT;
        end
        WAIT_RESULT: if (i_result_valid) r_state <= SEND;
        SEND:        if (w_tx_send && i_tx_busy) r_state <= TX_WAIT;
        TX_WAIT:     if (w_tx_done) r_state <= COLLECT;
        default:     r_state <= COLLECT;
      endcase
    end
  end

  uart_tx_handshake u_tx (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_byte    (w_reply),
    .i_tx_busy (i_tx_busy),
    .o_tx_data (o_tx_data),
    .o_tx_send (w_tx_send),
    .o_done    (w_tx_done)
  );

  assign o_tx_send     = w_tx_send;
  assign o_rx_ack      = r_rx_ack;
  assign o_frame_data  = r_frame;
  assign o_frame_valid = r_frame_valid;
  assign o_last_byte   = r_last_byte;
  assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_uart_frame_collector.sv
// Scoreboard bench: instance 0 is 16-byte result mode, instance 1 is 4-byte echo mode.
module tb_uart_frame_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst          [2];
  logic [7:0]   rx_data      [2];
  logic         rx_ready     [2];
  logic         rx_ack       [2];
  logic [7:0]   tx_data      [2];
  logic         tx_send      [2];
  logic         tx_busy      [2];
  logic         hold_busy    [2];
  logic         resp_busy    [2];
  logic         frame_valid  [2];
  logic         frame_ready  [2];
  logic         result_valid [2];
  logic [7:0]   result_data  [2];
  logic [7:0]   last_byte    [2];
  logic [7:0]   err_count    [2];
  logic [127:0] frame_obs    [2];
  logic [127:0] fd16;
  logic [31:0]  fd4;

  assign tx_busy[0]   = hold_busy[0] | resp_busy[0];
  assign tx_busy[1]   = hold_busy[1] | resp_busy[1];
  assign frame_obs[0] = fd16;
  assign frame_obs[1] = {96'd0, fd4};

  uart_frame_collector #(.FRAME_BYTES(16), .ECHO_MODE(1'b0)) u_dut16 (
    .i_clk(clk), .i_reset(rst[0]), .i_rx_data(rx_data[0]), .i_rx_ready(rx_ready[0]),
    .o_rx_ack(rx_ack[0]), .o_tx_data(tx_data[0]), .o_tx_send(tx_send[0]),
    .i_tx_busy(tx_busy[0]), .o_frame_data(fd16), .o_frame_valid(frame_valid[0]),
    .i_frame_ready(frame_ready[0]), .i_result_valid(result_valid[0]),
    .i_result_data(result_data[0]), .o_last_byte(last_byte[0]), .o_err_count(err_count[0])
  );

  uart_frame_collector #(.FRAME_BYTES(4), .ECHO_MODE(1'b1)) u_dut4 (
    .i_clk(clk), .i_reset(rst[1]), .i_rx_data(rx_data[1]), .i_rx_ready(rx_ready[1]),
    .o_rx_ack(rx_ack[1]), .o_tx_data(tx_data[1]), .o_tx_send(tx_send[1]),
    .i_tx_busy(tx_busy[1]), .o_frame_data(fd4), .o_frame_valid(frame_valid[1]),
    .i_frame_ready(frame_ready[1]), .i_result_valid(result_valid[1]),
    .i_result_data(result_data[1]), .o_last_byte(last_byte[1]), .o_err_count(err_count[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [127:0] exp_fq [2][$];
  logic [7:0]   exp_tq [2][$];
  int           tx_count    [2];
  int           frame_count [2];
  logic         prev_send   [2];
  int           resp_cnt    [2];

  // output monitor: frames and reply bytes are popped from the scoreboard
  initial begin
    for (int i = 0; i < 2; i++) begin
      tx_count[i] = 0; frame_count[i] = 0; prev_send[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (frame_valid[i] && frame_ready[i]) begin
          frame_count[i]++;
          check_val("frame_expected", 128'(exp_fq[i].size() != 0), 128'd1);
          if (exp_fq[i].size() != 0) check_val("frame_data", frame_obs[i], exp_fq[i].pop_front());
        end
        if (tx_send[i] && !prev_send[i]) begin
          tx_count[i]++;
          check_val("tx_expected", 128'(exp_tq[i].size() != 0), 128'd1);
          if (exp_tq[i].size() != 0) check_val("tx_data", 128'(tx_data[i]), 128'(exp_tq[i].pop_front()));
        end
        prev_send[i] = tx_send[i];
      end
    end
  end

  // UART transmitter model: busy for three cycles after each request
  initial begin
    for (int i = 0; i < 2; i++) begin
      resp_busy[i] = 1'b0; resp_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (resp_cnt[i] > 0) begin
          resp_cnt[i]--;
          if (resp_cnt[i] == 0) resp_busy[i] = 1'b0;
        end else if (tx_send[i] && !tx_busy[i]) begin
          resp_busy[i] = 1'b1;
          resp_cnt[i]  = 3;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] model_frame(input logic [7:0] first, input int nb);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < nb; k++) v = {v[119:0], 8'(first + 8'(k))};
    return v;
  endfunction

  task automatic send_byte_obs(input int idx, input logic [7:0] b, output logic fv, output logic ts);
    logic got, dropped;
    got = 1'b0; dropped = 1'b0; fv = 1'b0; ts = 1'b0;
    tick(1);
    rx_data[idx]  = b;
    rx_ready[idx] = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (rx_ack[idx]) begin
        got = 1'b1; fv = frame_valid[idx]; ts = tx_send[idx];
      end
    end
    check_val("rx_ack_seen", 128'(got), 128'd1);
    tick(1);
    rx_ready[idx] = 1'b0;
    for (int k = 0; k < 20 && !dropped; k++) begin
      @(negedge clk);
      if (!rx_ack[idx]) dropped = 1'b1;
    end
    check_val("rx_ack_drop", 128'(dropped), 128'd1);
  endtask

  task automatic send_byte(input int idx, input logic [7:0] b);
    logic fv, ts;
    send_byte_obs(idx, b, fv, ts);
  endtask

  task automatic send_range(input int idx, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) send_byte(idx, 8'(first + 8'(k)));
  endtask

  task automatic finish_frame(input int idx, input logic [127:0] exp, input int stall);
    logic fv, ts;
    int   fc0;
    fc0 = frame_count[idx];
    exp_fq[idx].push_back(exp);
    send_byte_obs(idx, 8'h2C, fv, ts);
    check_val("frame_valid_latency", 128'(fv), 128'd1);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check_val("stall_valid", 128'(frame_valid[idx]), 128'd1);
      check_val("stall_data", frame_obs[idx], exp);
    end
    tick(1);
    frame_ready[idx] = 1'b1;
    tick(1);
    frame_ready[idx] = 1'b0;
    check_val("frame_valid_drop", 128'(frame_valid[idx]), 128'd0);
    check_val("frame_count", 128'(frame_count[idx]), 128'(fc0 + 1));
  endtask

  task automatic finish_reply(input int idx, input int n0);
    for (int k = 0; k < 200 && tx_count[idx] != n0 + 1; k++) tick(1);
    tick(10);
    check_val("tx_once", 128'(tx_count[idx]), 128'(n0 + 1));
  endtask

  task automatic reply(input int idx, input logic [7:0] r);
    int n0;
    n0 = tx_count[idx];
    exp_tq[idx].push_back(r);
    tick(2);
    result_valid[idx] = 1'b1;
    result_data[idx]  = r;
    tick(1);
    result_valid[idx] = 1'b0;
    finish_reply(idx, n0);
  endtask

  task automatic check_reset(input int idx);
    check_val("rst_rx_ack", 128'(rx_ack[idx]), 128'd0);
    check_val("rst_tx_send", 128'(tx_send[idx]), 128'd0);
    check_val("rst_tx_data", 128'(tx_data[idx]), 128'd0);
    check_val("rst_frame_valid", 128'(frame_valid[idx]), 128'd0);
    check_val("rst_frame_data", frame_obs[idx], 128'd0);
    check_val("rst_last_byte", 128'(last_byte[idx]), 128'd0);
    check_val("rst_err_count", 128'(err_count[idx]), 128'd0);
  endtask

  task automatic error_frame(input int idx, input logic [7:0] first, input int n, input logic [7:0] exp_err);
    logic fv, ts;
    int   n0, fc0;
    n0  = tx_count[idx];
    fc0 = frame_count[idx];
    send_range(idx, first, n);
    exp_tq[idx].push_back(8'h45);
    send_byte_obs(idx, 8'h2C, fv, ts);
    check_val("err_no_valid", 128'(fv), 128'd0);
    check_val("err_send_latency", 128'(ts), 128'd1);
    finish_reply(idx, n0);
    check_val("err_count", 128'(err_count[idx]), 128'(exp_err));
    check_val("err_no_frame", 128'(frame_count[idx]), 128'(fc0));
  endtask

  logic [7:0] echo_bytes [4];
  int         n0_main;
  logic       ack_seen;

  initial begin
    echo_bytes[0] = 8'hDE; echo_bytes[1] = 8'hAD; echo_bytes[2] = 8'hBE; echo_bytes[3] = 8'hEF;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; rx_data[i] = '0; rx_ready[i] = 1'b0; hold_busy[i] = 1'b0;
      frame_ready[i] = 1'b0; result_valid[i] = 1'b0; result_data[i] = '0;
    end
    tick(3);
    check_reset(0);
    check_reset(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick(2);

    // a result outside WAIT_RESULT must not produce a reply
    result_valid[0] = 1'b1; result_data[0] = 8'h99;
    tick(2);
    result_valid[0] = 1'b0;

    // full 16-byte frame, Frame_Ready held low 5 cycles, result 0x31
    send_range(0, 8'h00, 16);
    check_val("last_byte", 128'(last_byte[0]), 128'h0F);
    finish_frame(0, 128'h000102030405060708090A0B0C0D0E0F, 5);
    reply(0, 8'h31);

    // short frame and 17-byte overflow frame are both malformed
    error_frame(0, 8'h41, 2, 8'd1);
    check_val("last_byte_short", 128'(last_byte[0]), 128'h42);
    error_frame(0, 8'h10, 17, 8'd2);
    send_range(0, 8'h80, 16);
    finish_frame(0, model_frame(8'h80, 16), 0);
    reply(0, 8'h5A);

    // backpressure: byte held while waiting for result and during a long busy
    send_range(0, 8'hA0, 16);
    finish_frame(0, model_frame(8'hA0, 16), 0);
    tick(1);
    rx_data[0] = 8'h77; rx_ready[0] = 1'b1;
    tick(5);
    check_val("bp_ack_wait_result", 128'(rx_ack[0]), 128'd0);
    hold_busy[0] = 1'b1;
    n0_main = tx_count[0];
    exp_tq[0].push_back(8'h55);
    result_valid[0] = 1'b1; result_data[0] = 8'h55;
    tick(1);
    result_valid[0] = 1'b0;
    tick(20);
    check_val("bp_no_send_busy", 128'(tx_count[0]), 128'(n0_main));
    check_val("bp_ack_send", 128'(rx_ack[0]), 128'd0);
    hold_busy[0] = 1'b0;
    finish_reply(0, n0_main);
    ack_seen = 1'b0;
    for (int k = 0; k < 50 && !ack_seen; k++) begin
      @(negedge clk);
      if (rx_ack[0]) ack_seen = 1'b1;
    end
    check_val("bp_ack_after_reply", 128'(ack_seen), 128'd1);
    tick(1);
    rx_ready[0] = 1'b0;
    tick(3);
    check_val("bp_last_byte", 128'(last_byte[0]), 128'h77);
    send_range(0, 8'h78, 15);
    finish_frame(0, model_frame(8'h77, 16), 0);
    reply(0, 8'h66);

    // reset after 7 bytes
    send_range(0, 8'h30, 7);
    rst[0] = 1'b1;
    tick(2);
    check_reset(0);
    rst[0] = 1'b0;
    tick(2);

    // reset while a reply is pending in SEND
    hold_busy[0] = 1'b1;
    send_range(0, 8'h41, 1);
    send_byte(0, 8'h2C);
    tick(3);
    n0_main = tx_count[0];
    rst[0] = 1'b1;
    tick(2);
    hold_busy[0] = 1'b0;
    check_reset(0);
    rst[0] = 1'b0;
    tick(20);
    check_val("no_tx_after_reset", 128'(tx_count[0]), 128'(n0_main));
    send_range(0, 8'hC0, 16);
    finish_frame(0, model_frame(8'hC0, 16), 0);
    reply(0, 8'h21);

    // echo instance: reply is the last payload byte, no result needed
    n0_main = tx_count[1];
    for (int k = 0; k < 4; k++) send_byte(1, echo_bytes[k]);
    check_val("echo_last_byte", 128'(last_byte[1]), 128'hEF);
    exp_tq[1].push_back(8'hEF);
    finish_frame(1, 128'hDEADBEEF, 2);
    finish_reply(1, n0_main);
    error_frame(1, 8'h01, 3, 8'd1);

    for (int i = 0; i < 2; i++) begin
      check_val("frame_q_empty", 128'(exp_fq[i].size()), 128'd0);
      check_val("tx_q_empty", 128'(exp_tq[i].size()), 128'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
